// File: rtl/fast_pkg.sv
// Shared types and helpers for the FAST corner collector slice.
// Optional drop statistics are enabled with FAST_DROP_STATS_EN (see fast_corner_collector).
package fast_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned CNT_W   = 20;

    typedef struct packed {
        logic                   eof;
        logic [2*COORD_W-1:0]   data;
    } corner_rec_t;

    function automatic logic is_last_pixel(input logic [31:0] x, input logic [31:0] y,
                                           input int unsigned cols, input int unsigned rows);
        return (x == cols - 1) && (y == rows - 1);
    endfunction

endpackage

// File: rtl/fast_corner_fifo.sv
// Synchronous first-word-fall-through FIFO of collector records.
// The output register counts toward the DEPTH capacity reported through o_free/o_full.
module fast_corner_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter type         T     = fast_pkg::corner_rec_t,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  T            i_data,
    input  logic        i_pop,
    output logic        o_valid,
    output T            o_data,
    output logic        o_full,
    output logic [AW:0] o_free
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_mem_cnt;
    T              r_out;
    logic          r_out_valid;

    logic          w_pop;
    logic          w_load;
    logic [AW:0]   w_total;

    assign w_pop   = i_pop && r_out_valid;
    // Output register refills from storage one edge after a write lands there.
    assign w_load  = (r_mem_cnt != '0) && (!r_out_valid || w_pop);
    assign w_total = r_mem_cnt + {{AW{1'b0}}, r_out_valid};

    assign o_valid = r_out_valid;
    assign o_data  = r_out;
    assign o_full  = (w_total == (AW+1)'(DEPTH));
    assign o_free  = (AW+1)'(DEPTH) - w_total;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_cnt   <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_out    <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, w_load})
                2'b10:   r_mem_cnt <= r_mem_cnt + 1'b1;
                2'b01:   r_mem_cnt <= r_mem_cnt - 1'b1;
                default: r_mem_cnt <= r_mem_cnt;
            endcase
            if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fast_corner_collector.sv
// Sink of the FAST+NMS corner stream: buffers corners and appends one EOF count record per frame.
// Define FAST_DROP_STATS_EN to add the drop_cnt / last_drop_cnt statistics outputs.
module fast_corner_collector #(
    parameter int unsigned COL_NUM    = 640,
    parameter int unsigned ROW_NUM    = 480,
    parameter int unsigned COORD_W    = fast_pkg::COORD_W,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned CNT_W      = fast_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   iscorner,
    input  logic [COORD_W-1:0]     x_coord,
    input  logic [COORD_W-1:0]     y_coord,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [2*COORD_W-1:0]   m_data,
    output logic                   m_eof,
    output logic                   overflow
`ifdef FAST_DROP_STATS_EN
    ,
    output logic [15:0]            drop_cnt,
    output logic [15:0]            last_drop_cnt
`endif
);
    import fast_pkg::*;

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic                 eof;
        logic [2*COORD_W-1:0] data;
    } rec_t;

    logic             r_last_seen;
    logic             r_eof_pending;
    logic [CNT_W-1:0] r_cnt;
    logic             r_overflow;

    logic             w_is_last;
    logic             w_detect;
    logic             w_corner;
    logic             w_accept;
    logic             w_drop;
    logic             w_push;
    rec_t             w_push_rec;
    rec_t             w_out;
    logic             w_full;
    logic [AW:0]      w_free;

    assign w_is_last = is_last_pixel(32'(x_coord), 32'(y_coord), COL_NUM, ROW_NUM);
    assign w_detect  = ce && w_is_last && !r_last_seen;
    assign w_corner  = ce && iscorner;
    // The EOF write owns the cycle after detect; two free slots keep one spare for it.
    assign w_accept  = w_corner && !r_eof_pending && !w_full && (w_free >= (AW+1)'(2));
    assign w_drop    = w_corner && !w_accept;
    assign w_push    = w_accept || r_eof_pending;

    always_comb begin
        w_push_rec = '0;
        if (r_eof_pending) begin
            w_push_rec.eof  = 1'b1;
            w_push_rec.data = (2*COORD_W)'(r_cnt);
        end else begin
            w_push_rec.data = {y_coord, x_coord};
        end
    end

    fast_corner_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (rec_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_rec),
        .i_pop   (m_ready),
        .o_valid (m_valid),
        .o_data  (w_out),
        .o_full  (w_full),
        .o_free  (w_free)
    );

    assign m_data   = w_out.data;
    assign m_eof    = w_out.eof;
    assign overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_seen   <= 1'b0;
            r_eof_pending <= 1'b0;
            r_cnt         <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (ce) begin
                r_last_seen <= w_is_last;
            end
            r_eof_pending <= w_detect;
            if (r_eof_pending) begin
                r_cnt      <= '0;
                r_overflow <= w_drop;
            end else begin
                if (w_accept && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

`ifdef FAST_DROP_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [15:0] r_last_drop_cnt;

    assign drop_cnt      = r_drop_cnt;
    assign last_drop_cnt = r_last_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt      <= '0;
            r_last_drop_cnt <= '0;
        end else if (r_eof_pending) begin
            r_last_drop_cnt <= r_drop_cnt;
            r_drop_cnt      <= {15'd0, w_drop};
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fast_corner_collector.sv
// Scoreboard bench for fast_corner_collector: stimulus pushes expected records, a monitor pops and compares.
module tb_fast_corner_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        iscorner = 1'b0;
    logic [9:0]  x_coord = '0;
    logic [9:0]  y_coord = '0;
    logic        m_ready = 1'b0;
    logic        m_valid;
    logic [19:0] m_data;
    logic        m_eof;
    logic        overflow;
`ifdef FAST_DROP_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] last_drop_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [20:0] exp_q[$];
    bit          rand_ready = 1'b0;

    fast_corner_collector #(
        .COL_NUM    (640),
        .ROW_NUM    (480),
        .COORD_W    (10),
        .FIFO_DEPTH (64),
        .CNT_W      (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .iscorner (iscorner),
        .x_coord  (x_coord),
        .y_coord  (y_coord),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_eof    (m_eof),
        .overflow (overflow)
`ifdef FAST_DROP_STATS_EN
        ,
        .drop_cnt      (drop_cnt),
        .last_drop_cnt (last_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void exp_corner(input int x, input int y);
        exp_q.push_back({1'b0, 10'(y), 10'(x)});
    endfunction

    function automatic void exp_eof(input int n);
        exp_q.push_back({1'b1, 20'(n)});
    endfunction

    // Monitor: samples on the falling edge, the handshake completes on the next rising edge.
    logic        prev_stall = 1'b0;
    logic [20:0] prev_rec = '0;
    initial begin
        logic [20:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_stable", {10'd0, m_valid, m_eof, m_data}, {10'd0, 1'b1, prev_rec});
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_record: got 0x%0h expected none", {m_eof, m_data});
                    end else begin
                        e = exp_q.pop_front();
                        check("record", {11'd0, m_eof, m_data}, {11'd0, e});
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_rec   = {m_eof, m_data};
            end
        end
    end

    task automatic step(input logic c, input logic i, input int x, input int y);
        ce       = c;
        iscorner = i;
        x_coord  = 10'(x);
        y_coord  = 10'(y);
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            idle();
            n++;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
        exp_q.delete();
        idle();
        idle();
        check({name, "_no_extra"}, {31'd0, m_valid}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset state and a basic frame
        check("rst_m_valid", {31'd0, m_valid}, 0);
        check("rst_m_eof", {31'd0, m_eof}, 0);
        check("rst_m_data", {12'd0, m_data}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        m_ready = 1'b1;
        exp_corner(5, 3);     step(1, 1, 5, 3);
        exp_corner(100, 200); step(1, 1, 100, 200);
        exp_corner(639, 479); step(1, 1, 639, 479);
        exp_eof(3);           step(1, 0, 0, 0);
        check("t1_overflow", {31'd0, overflow}, 0);
        drain("t1", 50);

        // 2: stalled output, 70 corners into a 64-entry FIFO
        m_ready = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (i < 63) exp_corner(i, 1);
            step(1, 1, i, 1);
        end
        check("t2_overflow_set", {31'd0, overflow}, 1);
        check("t2_valid_stalled", {31'd0, m_valid}, 1);
`ifdef FAST_DROP_STATS_EN
        check("t2_drop_cnt", {16'd0, drop_cnt}, 7);
`endif
        step(1, 0, 639, 479);
        exp_eof(63);
        step(1, 0, 0, 0);
        check("t2_overflow_clr", {31'd0, overflow}, 0);
`ifdef FAST_DROP_STATS_EN
        check("t2_last_drop_cnt", {16'd0, last_drop_cnt}, 7);
        check("t2_drop_cnt_clr", {16'd0, drop_cnt}, 0);
`endif
        m_ready = 1'b1;
        drain("t2", 200);

        // 3: held last pixel gives one EOF; (0,0) re-arms detection
        exp_eof(0);
        repeat (5) step(1, 0, 639, 479);
        step(1, 0, 0, 0);
        exp_eof(0);
        step(1, 0, 639, 479);
        step(1, 0, 0, 0);
        drain("t3", 50);

        // 4: corner colliding with the EOF-write cycle is dropped into the new frame
        exp_corner(10, 10); step(1, 1, 10, 10);
        step(1, 0, 639, 479);
        exp_eof(1);         step(1, 1, 0, 0);
        check("t4_overflow_collision", {31'd0, overflow}, 1);
`ifdef FAST_DROP_STATS_EN
        check("t4_drop_cnt", {16'd0, drop_cnt}, 1);
`endif
        exp_corner(1, 0);     step(1, 1, 1, 0);
        exp_corner(639, 479); step(1, 1, 639, 479);
        exp_eof(2);           step(1, 0, 0, 0);
        check("t4_overflow_clr", {31'd0, overflow}, 0);
        drain("t4", 50);

        // 5: reset mid-frame with buffered corners
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) step(1, 1, i, 2);
        check("t5_valid_before_rst", {31'd0, m_valid}, 1);
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        check("t5_valid_after_rst", {31'd0, m_valid}, 0);
        idle();
        idle();
        check("t5_fifo_empty", {31'd0, m_valid}, 0);
        m_ready = 1'b1;
        exp_corner(1, 1); step(1, 1, 1, 1);
        exp_corner(2, 1); step(1, 1, 2, 1);
        step(1, 0, 639, 479);
        exp_eof(2);       step(1, 0, 0, 0);
        drain("t5", 50);

        // 6: random backpressure, corners every third cycle
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (i % 3 == 0) begin
                exp_corner(i / 3, 6);
                step(1, 1, i / 3, 6);
            end else begin
                step(1, 0, 600, 7);
            end
        end
        check("t6_overflow", {31'd0, overflow}, 0);
        rand_ready = 1'b0;
        m_ready = 1'b1;
        step(1, 0, 639, 479);
        exp_eof(334);
        step(1, 0, 0, 0);
        drain("t6", 2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
